// File: rtl/cache_block_transfer.sv
// rtl/cache_block_transfer.sv - cache line fill/evict transfer engine
//
// Purpose:
//    Moves whole cache blocks between the cache block memory and main memory.
//    Fill:  collects N_WORDS_PER_BLOCK words from the ext read stream, then
//           commits them with a single block write to the cache memory.
//    Evict: reads one block from the cache memory and serializes it onto the
//           ext write stream, word 0 first, with wlast on the final word.
//
// Ports:
//    clock_i, reset_n_i     clock (rising edge), asynchronous active-low reset
//    cmd_valid_i/ready_o    command handshake; cmd_evict_i selects direction,
//                           cmd_addr_i is the cache block index
//    done_o                 one-cycle pulse when a command completes
//    mem_addr_o             block index presented to the cache memory
//    mem_wren_block_o       one-cycle block write strobe (fill only)
//    mem_data_block_o       block write data, word g at [BW_DATA*g +: BW_DATA]
//    mem_data_block_i       block read data, valid one cycle after mem_addr_o
//    ext_rdata_i/rvalid_i/rready_o           fill word stream from main memory
//    ext_wdata_o/wvalid_o/wready_i/wlast_o   evict word stream to main memory

module cache_block_transfer #(
   parameter int BW_DATA           = 32,
   parameter int N_BLOCKS          = 64,
   parameter int N_WORDS_PER_BLOCK = 4,
   localparam int BW_ADDR          = $clog2(N_BLOCKS),
   localparam int BW_OFFSET        = $clog2(N_WORDS_PER_BLOCK),
   localparam int BW_BLOCK         = BW_DATA * N_WORDS_PER_BLOCK
) (
   input  logic                clock_i,
   input  logic                reset_n_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic                cmd_evict_i,
   input  logic [BW_ADDR-1:0]  cmd_addr_i,
   output logic                done_o,
   output logic [BW_ADDR-1:0]  mem_addr_o,
   output logic                mem_wren_block_o,
   output logic [BW_BLOCK-1:0] mem_data_block_o,
   input  logic [BW_BLOCK-1:0] mem_data_block_i,
   input  logic [BW_DATA-1:0]  ext_rdata_i,
   input  logic                ext_rvalid_i,
   output logic                ext_rready_o,
   output logic [BW_DATA-1:0]  ext_wdata_o,
   output logic                ext_wvalid_o,
   input  logic                ext_wready_i,
   output logic                ext_wlast_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_FILL_WRITE,
      S_EVICT_READ,
      S_EVICT_LATCH,
      S_EVICT_SEND,
      S_DONE
   } state_t;

   localparam logic [BW_OFFSET-1:0] LAST_CNT = BW_OFFSET'(N_WORDS_PER_BLOCK - 1);

   state_t                r_state;
   state_t                w_next_state;
   logic [BW_ADDR-1:0]    r_addr;
   logic [BW_OFFSET-1:0]  r_cnt;
   logic [BW_BLOCK-1:0]   r_buf;

   logic                  w_cmd_ready;
   logic                  w_rready;
   logic                  w_wvalid;
   logic                  w_wren;
   logic                  w_done;
   logic                  w_last_word;
   logic                  w_cmd_hs;
   logic                  w_r_hs;
   logic                  w_w_hs;
   logic [BW_DATA-1:0]    w_send_word;

   assign w_last_word = (r_cnt == LAST_CNT);
   assign w_cmd_hs    = cmd_valid_i  & w_cmd_ready;
   assign w_r_hs      = ext_rvalid_i & w_rready;
   assign w_w_hs      = ext_wready_i & w_wvalid;
   assign w_send_word = r_buf[BW_DATA*r_cnt +: BW_DATA];

   // State register
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state and per-state strobes
   always_comb begin
      w_next_state = r_state;
      w_cmd_ready  = 1'b0;
      w_rready     = 1'b0;
      w_wvalid     = 1'b0;
      w_wren       = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cmd_ready = 1'b1;
            if (cmd_valid_i) begin
               w_next_state = cmd_evict_i ? S_EVICT_READ : S_FILL;
            end
         end
         S_FILL: begin
            w_rready = 1'b1;
            if (ext_rvalid_i && w_last_word) begin
               w_next_state = S_FILL_WRITE;
            end
         end
         S_FILL_WRITE: begin
            w_wren       = 1'b1;
            w_next_state = S_DONE;
         end
         S_EVICT_READ: begin
            // cache memory sees r_addr this cycle; data arrives next cycle
            w_next_state = S_EVICT_LATCH;
         end
         S_EVICT_LATCH: begin
            w_next_state = S_EVICT_SEND;
         end
         S_EVICT_SEND: begin
            w_wvalid = 1'b1;
            if (ext_wready_i && w_last_word) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            w_done       = 1'b1;
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Address, word counter and block buffer
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_addr <= '0;
         r_cnt  <= '0;
         r_buf  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_cmd_hs) begin
                  r_addr <= cmd_addr_i;
                  r_cnt  <= '0;
               end
            end
            S_FILL: begin
               if (w_r_hs) begin
                  r_buf[BW_DATA*r_cnt +: BW_DATA] <= ext_rdata_i;
                  // power-of-two block size: last beat wraps the counter to 0
                  r_cnt <= r_cnt + BW_OFFSET'(1);
               end
            end
            S_EVICT_LATCH: begin
               r_buf <= mem_data_block_i;
            end
            S_EVICT_SEND: begin
               if (w_w_hs) begin
                  r_cnt <= r_cnt + BW_OFFSET'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // cmd_ready is held low while reset is asserted, high as soon as it releases
   assign cmd_ready_o      = w_cmd_ready & reset_n_i;
   assign ext_rready_o     = w_rready;
   assign ext_wvalid_o     = w_wvalid;
   assign ext_wdata_o      = w_wvalid ? w_send_word : '0;
   assign ext_wlast_o      = w_wvalid & w_last_word;
   assign mem_wren_block_o = w_wren;
   assign mem_data_block_o = r_buf;
   assign mem_addr_o       = r_addr;
   assign done_o           = w_done;

endmodule

// File: tb/tb_cache_block_transfer.sv
// tb/tb_cache_block_transfer.sv - directed self-checking bench for cache_block_transfer

module tb_cache_block_transfer;

   localparam int BW_DATA  = 32;
   localparam int N_BLOCKS = 64;
   localparam int NW       = 4;
   localparam int BW_ADDR  = 6;
   localparam int BW_BLOCK = 128;

   logic                clock_i = 1'b0;
   logic                reset_n_i = 1'b0;
   logic                cmd_valid_i = 1'b0;
   logic                cmd_ready_o;
   logic                cmd_evict_i = 1'b0;
   logic [BW_ADDR-1:0]  cmd_addr_i = '0;
   logic                done_o;
   logic [BW_ADDR-1:0]  mem_addr_o;
   logic                mem_wren_block_o;
   logic [BW_BLOCK-1:0] mem_data_block_o;
   logic [BW_BLOCK-1:0] mem_data_block_i;
   logic [BW_DATA-1:0]  ext_rdata_i = '0;
   logic                ext_rvalid_i = 1'b0;
   logic                ext_rready_o;
   logic [BW_DATA-1:0]  ext_wdata_o;
   logic                ext_wvalid_o;
   logic                ext_wready_i = 1'b0;
   logic                ext_wlast_o;

   int vectors = 0;
   int miscompares = 0;

   logic [BW_BLOCK-1:0] mem_model [0:N_BLOCKS-1];
   int                  wren_cnt = 0;
   logic [BW_ADDR-1:0]  wr_addr;
   logic [BW_BLOCK-1:0] wr_data;

   cache_block_transfer #(
      .BW_DATA(BW_DATA),
      .N_BLOCKS(N_BLOCKS),
      .N_WORDS_PER_BLOCK(NW)
   ) dut (
      .clock_i(clock_i),
      .reset_n_i(reset_n_i),
      .cmd_valid_i(cmd_valid_i),
      .cmd_ready_o(cmd_ready_o),
      .cmd_evict_i(cmd_evict_i),
      .cmd_addr_i(cmd_addr_i),
      .done_o(done_o),
      .mem_addr_o(mem_addr_o),
      .mem_wren_block_o(mem_wren_block_o),
      .mem_data_block_o(mem_data_block_o),
      .mem_data_block_i(mem_data_block_i),
      .ext_rdata_i(ext_rdata_i),
      .ext_rvalid_i(ext_rvalid_i),
      .ext_rready_o(ext_rready_o),
      .ext_wdata_o(ext_wdata_o),
      .ext_wvalid_o(ext_wvalid_o),
      .ext_wready_i(ext_wready_i),
      .ext_wlast_o(ext_wlast_o)
   );

   always #5 clock_i = ~clock_i;

   // synchronous-read cache memory: data one cycle after the address
   always @(posedge clock_i) mem_data_block_i <= mem_model[mem_addr_o];

   // block write monitor
   always @(negedge clock_i) begin
      if (mem_wren_block_o === 1'b1) begin
         wren_cnt = wren_cnt + 1;
         wr_addr  = mem_addr_o;
         wr_data  = mem_data_block_o;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      reset_n_i = 1'b0;
      repeat (3) @(negedge clock_i);
      vectors++; if (cmd_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready_o); end
      vectors++; if (done_o !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done_o); end
      vectors++; if (mem_wren_block_o !== 1'b0) begin miscompares++; $display("FAIL reset_wren: got %b want 0", mem_wren_block_o); end
      vectors++; if (ext_rready_o !== 1'b0) begin miscompares++; $display("FAIL reset_rready: got %b want 0", ext_rready_o); end
      vectors++; if (ext_wvalid_o !== 1'b0 || ext_wlast_o !== 1'b0) begin miscompares++; $display("FAIL reset_wvalid_wlast: got %b%b want 00", ext_wvalid_o, ext_wlast_o); end
      vectors++; if (mem_addr_o !== '0) begin miscompares++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr_o); end
      vectors++; if (ext_wdata_o !== '0) begin miscompares++; $display("FAIL reset_wdata: got %h want 0", ext_wdata_o); end
      vectors++; if (mem_data_block_o !== '0) begin miscompares++; $display("FAIL reset_block_data: got %h want 0", mem_data_block_o); end
      reset_n_i = 1'b1;
      #1;
      vectors++; if (cmd_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_release_cmd_ready: got %b want 1", cmd_ready_o); end
   endtask

   task automatic test_fill_back_to_back();
      logic [BW_BLOCK-1:0] exp_blk;
      int w0;
      exp_blk = {32'h44, 32'h33, 32'h22, 32'h11};
      @(negedge clock_i);
      w0 = wren_cnt;
      vectors++; if (cmd_ready_o !== 1'b1) begin miscompares++; $display("FAIL b2b_idle_ready: got %b want 1", cmd_ready_o); end
      cmd_valid_i = 1'b1; cmd_evict_i = 1'b0; cmd_addr_i = 6'd5;
      @(negedge clock_i);
      cmd_valid_i = 1'b0;
      vectors++; if (cmd_ready_o !== 1'b0 || ext_rready_o !== 1'b1) begin miscompares++; $display("FAIL b2b_fill_entry: got ready=%b rready=%b want 0 1", cmd_ready_o, ext_rready_o); end
      for (int i = 0; i < NW; i++) begin
         vectors++; if (mem_wren_block_o !== 1'b0) begin miscompares++; $display("FAIL b2b_early_wren: got %b want 0 at beat %0d", mem_wren_block_o, i); end
         ext_rvalid_i = 1'b1; ext_rdata_i = 32'h11 * (i + 1);
         @(negedge clock_i);
      end
      ext_rvalid_i = 1'b0;
      vectors++; if (mem_wren_block_o !== 1'b1) begin miscompares++; $display("FAIL b2b_wren: got %b want 1", mem_wren_block_o); end
      vectors++; if (mem_addr_o !== 6'd5) begin miscompares++; $display("FAIL b2b_wr_addr: got %h want 05", mem_addr_o); end
      vectors++; if (mem_data_block_o !== exp_blk) begin miscompares++; $display("FAIL b2b_wr_data: got %h want %h", mem_data_block_o, exp_blk); end
      vectors++; if (ext_rready_o !== 1'b0 || done_o !== 1'b0) begin miscompares++; $display("FAIL b2b_write_strobes: got rready=%b done=%b want 0 0", ext_rready_o, done_o); end
      @(negedge clock_i);
      vectors++; if (done_o !== 1'b1 || mem_wren_block_o !== 1'b0) begin miscompares++; $display("FAIL b2b_done: got done=%b wren=%b want 1 0", done_o, mem_wren_block_o); end
      @(negedge clock_i);
      vectors++; if (done_o !== 1'b0 || cmd_ready_o !== 1'b1) begin miscompares++; $display("FAIL b2b_back_idle: got done=%b ready=%b want 0 1", done_o, cmd_ready_o); end
      vectors++; if (wren_cnt - w0 !== 1) begin miscompares++; $display("FAIL b2b_wren_count: got %0d want 1", wren_cnt - w0); end
   endtask

   task automatic test_fill_gaps();
      logic [BW_BLOCK-1:0] exp_blk;
      int w0;
      int g;
      exp_blk = {32'h44, 32'h33, 32'h22, 32'h11};
      w0 = wren_cnt;
      cmd_valid_i = 1'b1; cmd_evict_i = 1'b0; cmd_addr_i = 6'd7;
      @(negedge clock_i);
      cmd_valid_i = 1'b0;
      for (int i = 0; i < NW; i++) begin
         g = $urandom_range(0, 3);
         ext_rvalid_i = 1'b0;
         for (int s = 0; s < g; s++) begin
            @(negedge clock_i);
            vectors++; if (mem_wren_block_o !== 1'b0 || ext_rready_o !== 1'b1) begin miscompares++; $display("FAIL gap_wait: got wren=%b rready=%b want 0 1", mem_wren_block_o, ext_rready_o); end
         end
         ext_rvalid_i = 1'b1; ext_rdata_i = 32'h11 * (i + 1);
         @(negedge clock_i);
      end
      ext_rvalid_i = 1'b0;
      vectors++; if (mem_wren_block_o !== 1'b1 || mem_addr_o !== 6'd7) begin miscompares++; $display("FAIL gap_wren: got wren=%b addr=%h want 1 07", mem_wren_block_o, mem_addr_o); end
      vectors++; if (mem_data_block_o !== exp_blk) begin miscompares++; $display("FAIL gap_wr_data: got %h want %h", mem_data_block_o, exp_blk); end
      repeat (2) @(negedge clock_i);
      vectors++; if (cmd_ready_o !== 1'b1 || wren_cnt - w0 !== 1) begin miscompares++; $display("FAIL gap_finish: got ready=%b wrens=%0d want 1 1", cmd_ready_o, wren_cnt - w0); end
   endtask

   task automatic test_evict_backpressure();
      logic [BW_DATA-1:0] exp_w [NW];
      int stalls [NW];
      int w0;
      exp_w  = '{32'h0000000A, 32'h0000000B, 32'h0000000C, 32'h0000000D};
      stalls = '{1, 0, 2, 1};
      w0 = wren_cnt;
      ext_wready_i = 1'b0;
      cmd_valid_i = 1'b1; cmd_evict_i = 1'b1; cmd_addr_i = 6'd9;
      @(negedge clock_i);
      cmd_valid_i = 1'b0; cmd_evict_i = 1'b0;
      vectors++; if (mem_addr_o !== 6'd9 || ext_wvalid_o !== 1'b0) begin miscompares++; $display("FAIL ev_read: got addr=%h wvalid=%b want 09 0", mem_addr_o, ext_wvalid_o); end
      @(negedge clock_i);
      vectors++; if (ext_wvalid_o !== 1'b0) begin miscompares++; $display("FAIL ev_latch_wvalid: got %b want 0", ext_wvalid_o); end
      @(negedge clock_i);
      for (int i = 0; i < NW; i++) begin
         for (int s = 0; s < stalls[i]; s++) begin
            vectors++; if (ext_wvalid_o !== 1'b1 || ext_wdata_o !== exp_w[i] || ext_wlast_o !== (i == NW - 1)) begin miscompares++; $display("FAIL ev_stall_word%0d: got v=%b d=%h l=%b want 1 %h %b", i, ext_wvalid_o, ext_wdata_o, ext_wlast_o, exp_w[i], (i == NW - 1)); end
            ext_wready_i = 1'b0;
            @(negedge clock_i);
         end
         vectors++; if (ext_wvalid_o !== 1'b1 || ext_wdata_o !== exp_w[i] || ext_wlast_o !== (i == NW - 1)) begin miscompares++; $display("FAIL ev_word%0d: got v=%b d=%h l=%b want 1 %h %b", i, ext_wvalid_o, ext_wdata_o, ext_wlast_o, exp_w[i], (i == NW - 1)); end
         vectors++; if (done_o !== 1'b0 || mem_wren_block_o !== 1'b0) begin miscompares++; $display("FAIL ev_send_strobes: got done=%b wren=%b want 0 0", done_o, mem_wren_block_o); end
         ext_wready_i = 1'b1;
         @(negedge clock_i);
         ext_wready_i = 1'b0;
      end
      vectors++; if (done_o !== 1'b1 || ext_wvalid_o !== 1'b0 || ext_wlast_o !== 1'b0) begin miscompares++; $display("FAIL ev_done: got done=%b wvalid=%b wlast=%b want 1 0 0", done_o, ext_wvalid_o, ext_wlast_o); end
      @(negedge clock_i);
      vectors++; if (cmd_ready_o !== 1'b1 || wren_cnt != w0) begin miscompares++; $display("FAIL ev_finish: got ready=%b wrens=%0d want 1 0", cmd_ready_o, wren_cnt - w0); end
   endtask

   task automatic test_reset_mid_fill();
      logic [BW_BLOCK-1:0] exp_blk;
      int w0;
      exp_blk = {32'h88, 32'h77, 32'h66, 32'h55};
      w0 = wren_cnt;
      cmd_valid_i = 1'b1; cmd_evict_i = 1'b0; cmd_addr_i = 6'd3;
      @(negedge clock_i);
      cmd_valid_i = 1'b0;
      ext_rvalid_i = 1'b1; ext_rdata_i = 32'h99; @(negedge clock_i);
      ext_rdata_i = 32'hAA; @(negedge clock_i);
      ext_rvalid_i = 1'b0;
      reset_n_i = 1'b0;
      #1;
      vectors++; if (ext_rready_o !== 1'b0 || cmd_ready_o !== 1'b0 || mem_wren_block_o !== 1'b0) begin miscompares++; $display("FAIL rst_mid_outputs: got rready=%b ready=%b wren=%b want 0 0 0", ext_rready_o, cmd_ready_o, mem_wren_block_o); end
      repeat (2) @(negedge clock_i);
      reset_n_i = 1'b1;
      #1;
      vectors++; if (cmd_ready_o !== 1'b1) begin miscompares++; $display("FAIL rst_mid_release_ready: got %b want 1", cmd_ready_o); end
      @(negedge clock_i);
      vectors++; if (wren_cnt != w0) begin miscompares++; $display("FAIL rst_mid_no_wren: got %0d want 0", wren_cnt - w0); end
      cmd_valid_i = 1'b1; cmd_addr_i = 6'd2;
      @(negedge clock_i);
      cmd_valid_i = 1'b0;
      for (int i = 0; i < NW; i++) begin
         ext_rvalid_i = 1'b1; ext_rdata_i = 32'h55 + 32'h11 * i;
         @(negedge clock_i);
      end
      ext_rvalid_i = 1'b0;
      vectors++; if (mem_wren_block_o !== 1'b1 || mem_addr_o !== 6'd2 || mem_data_block_o !== exp_blk) begin miscompares++; $display("FAIL rst_mid_refill: got wren=%b addr=%h data=%h want 1 02 %h", mem_wren_block_o, mem_addr_o, mem_data_block_o, exp_blk); end
      repeat (2) @(negedge clock_i);
      vectors++; if (wren_cnt - w0 !== 1) begin miscompares++; $display("FAIL rst_mid_wren_count: got %0d want 1", wren_cnt - w0); end
   endtask

   task automatic test_cmd_gating();
      int accepts;
      int done_at;
      logic [BW_BLOCK-1:0] exp_blk;
      exp_blk = {32'h1004, 32'h1003, 32'h1002, 32'h1001};
      accepts = 0; done_at = -1;
      cmd_valid_i = 1'b1; cmd_evict_i = 1'b0; cmd_addr_i = 6'd4;
      for (int c = 0; c < 7; c++) begin
         if (cmd_ready_o === 1'b1) accepts++;
         if (done_o === 1'b1) done_at = c;
         ext_rvalid_i = (c >= 1 && c <= 4);
         ext_rdata_i  = 32'h1000 + c;
         @(negedge clock_i);
      end
      ext_rvalid_i = 1'b0;
      vectors++; if (accepts !== 1) begin miscompares++; $display("FAIL gate_accepts: got %0d want 1", accepts); end
      vectors++; if (done_at !== 6) begin miscompares++; $display("FAIL gate_done_cycle: got %0d want 6", done_at); end
      vectors++; if (cmd_ready_o !== 1'b1) begin miscompares++; $display("FAIL gate_reaccept: got %b want 1", cmd_ready_o); end
      vectors++; if (wr_addr !== 6'd4 || wr_data !== exp_blk) begin miscompares++; $display("FAIL gate_block: got %h %h want 04 %h", wr_addr, wr_data, exp_blk); end
      @(negedge clock_i);
      cmd_valid_i = 1'b0;
      vectors++; if (ext_rready_o !== 1'b1 || cmd_ready_o !== 1'b0) begin miscompares++; $display("FAIL gate_second_fill: got rready=%b ready=%b want 1 0", ext_rready_o, cmd_ready_o); end
      for (int i = 0; i < NW; i++) begin
         ext_rvalid_i = 1'b1; ext_rdata_i = 32'h2000 + i;
         @(negedge clock_i);
      end
      ext_rvalid_i = 1'b0;
      @(negedge clock_i);
      vectors++; if (done_o !== 1'b1) begin miscompares++; $display("FAIL gate_second_done: got %b want 1", done_o); end
      @(negedge clock_i);
   endtask

   task automatic test_stray_inputs();
      logic [BW_BLOCK-1:0] exp_blk;
      logic [BW_DATA-1:0] exp_w [NW];
      int w0;
      exp_blk = {32'h24, 32'h23, 32'h22, 32'h21};
      exp_w   = '{32'h0000000A, 32'h0000000B, 32'h0000000C, 32'h0000000D};
      cmd_valid_i = 1'b0;
      ext_rvalid_i = 1'b1; ext_rdata_i = 32'hDEAD; ext_wready_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock_i);
         vectors++; if (cmd_ready_o !== 1'b1 || ext_rready_o !== 1'b0 || ext_wvalid_o !== 1'b0 || done_o !== 1'b0) begin miscompares++; $display("FAIL stray_idle: got ready=%b rready=%b wvalid=%b done=%b want 1 0 0 0", cmd_ready_o, ext_rready_o, ext_wvalid_o, done_o); end
      end
      // fill with wready held high the whole time
      cmd_valid_i = 1'b1; cmd_addr_i = 6'd6; ext_rvalid_i = 1'b0;
      @(negedge clock_i);
      cmd_valid_i = 1'b0;
      for (int i = 0; i < NW; i++) begin
         vectors++; if (ext_wvalid_o !== 1'b0) begin miscompares++; $display("FAIL stray_fill_wvalid: got %b want 0", ext_wvalid_o); end
         ext_rvalid_i = 1'b1; ext_rdata_i = 32'h21 + i;
         @(negedge clock_i);
      end
      ext_rdata_i = 32'hBAD;
      vectors++; if (mem_wren_block_o !== 1'b1 || mem_data_block_o !== exp_blk) begin miscompares++; $display("FAIL stray_fill_block: got wren=%b data=%h want 1 %h", mem_wren_block_o, mem_data_block_o, exp_blk); end
      repeat (2) @(negedge clock_i);
      // evict with rvalid held high the whole time
      w0 = wren_cnt;
      cmd_valid_i = 1'b1; cmd_evict_i = 1'b1; cmd_addr_i = 6'd9;
      @(negedge clock_i);
      cmd_valid_i = 1'b0; cmd_evict_i = 1'b0;
      repeat (2) @(negedge clock_i);
      for (int i = 0; i < NW; i++) begin
         vectors++; if (ext_wvalid_o !== 1'b1 || ext_wdata_o !== exp_w[i] || ext_rready_o !== 1'b0) begin miscompares++; $display("FAIL stray_ev_word%0d: got v=%b d=%h rready=%b want 1 %h 0", i, ext_wvalid_o, ext_wdata_o, ext_rready_o, exp_w[i]); end
         @(negedge clock_i);
      end
      vectors++; if (done_o !== 1'b1) begin miscompares++; $display("FAIL stray_ev_done: got %b want 1", done_o); end
      ext_rvalid_i = 1'b0; ext_wready_i = 1'b0;
      @(negedge clock_i);
      vectors++; if (wren_cnt != w0 || cmd_ready_o !== 1'b1) begin miscompares++; $display("FAIL stray_ev_finish: got wrens=%0d ready=%b want 0 1", wren_cnt - w0, cmd_ready_o); end
   endtask

   initial begin
      for (int a = 0; a < N_BLOCKS; a++) mem_model[a] = {4{32'(a) | 32'h5A000000}};
      mem_model[9] = {32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A};
      test_reset();
      test_fill_back_to_back();
      test_fill_gaps();
      test_evict_backpressure();
      test_reset_mid_fill();
      test_cmd_gating();
      test_stray_inputs();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cache_block_transfer.md
Name: cache_block_transfer

Overview:
- Line-transfer engine on the far side of the cache block memory.
- Fill: accepts a word stream from main memory, assembles a block, commits it with one block write to the cache memory.
- Evict: reads a block from the cache memory and serializes it into a word stream toward main memory.
- Sits between the cache controller (command side) and the cache memory / external memory port.

Parameters:
- BW_DATA, 32, bits per word.
- N_BLOCKS, 64, cache block entries; BW_ADDR = clog2(N_BLOCKS).
- N_WORDS_PER_BLOCK, 4, words per block; power of two, >=2; BW_OFFSET = clog2(N_WORDS_PER_BLOCK); BW_BLOCK = BW_DATA*N_WORDS_PER_BLOCK.

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_evict_i  in  1  1 = evict (cache->ext), 0 = fill (ext->cache).
- cmd_addr_i  in  BW_ADDR  cache block index.
- done_o  out  1  one-cycle pulse at command completion.
- mem_addr_o  out  BW_ADDR  block address to cache memory.
- mem_wren_block_o  out  1  block write strobe to cache memory.
- mem_data_block_o  out  BW_BLOCK  block write data; word g at bits [BW_DATA*g +: BW_DATA].
- mem_data_block_i  in  BW_BLOCK  block read data; valid one cycle after mem_addr_o is presented.
- ext_rdata_i  in  BW_DATA  fill word from main memory.
- ext_rvalid_i  in  1  fill word valid.
- ext_rready_o  out  1  fill word accepted when rvalid&rready.
- ext_wdata_o  out  BW_DATA  evict word to main memory.
- ext_wvalid_o  out  1  evict word valid.
- ext_wready_i  in  1  evict word accepted when wvalid&wready.
- ext_wlast_o  out  1  marks final evict word.

Behaviour:
- Reset (async assert, sync release): state IDLE; word counter 0; block buffer 0; mem_addr_o 0; all strobes 0 (done_o, mem_wren_block_o, ext_rready_o, ext_wvalid_o, ext_wlast_o); ext_wdata_o 0; cmd_ready_o 0 during reset, 1 in the first IDLE cycle after release.
- States: IDLE, FILL, FILL_WRITE, EVICT_READ, EVICT_LATCH, EVICT_SEND, DONE.
- IDLE:
  - cmd_ready_o = 1 only in IDLE.
  - On handshake: latch cmd_addr_i into an address register that drives mem_addr_o until the next accept; clear the counter.
  - Go to EVICT_READ if cmd_evict_i = 1, else FILL.
- FILL:
  - ext_rready_o = 1.
  - On each handshake: buffer word[counter] <= ext_rdata_i; counter +1.
  - Handshake with counter == N_WORDS_PER_BLOCK-1 -> FILL_WRITE; counter wraps to 0.
  - Beats may be non-consecutive (rvalid gaps allowed).
- FILL_WRITE: mem_wren_block_o = 1 for exactly one cycle; mem_data_block_o = buffer (word 0 in low bits) -> DONE.
- EVICT_READ: one cycle with mem_addr_o presented -> EVICT_LATCH.
- EVICT_LATCH: buffer <= mem_data_block_i -> EVICT_SEND.
- EVICT_SEND:
  - ext_wvalid_o = 1; ext_wdata_o = buffer word[counter]; ext_wlast_o = (counter == N_WORDS_PER_BLOCK-1).
  - wvalid, wdata and wlast stay stable while wready = 0.
  - Handshake advances the counter; handshake on the last word -> DONE.
- DONE: done_o = 1 for one cycle -> IDLE.
- Latency:
  - Fill: last r-handshake at cycle X -> wren at X+1, done at X+2, cmd_ready at X+3.
  - Evict: accept at T -> first wvalid at T+3; last w-handshake at Y -> done at Y+1.
- Inputs outside their window are ignored: ext_rvalid_i outside FILL; ext_wready_i outside EVICT_SEND; cmd_valid_i outside IDLE.
- mem_wren_block_o is never asserted in any evict state.
- mem_data_block_o always reflects the buffer; it is only meaningful during the wren cycle.
- Reset mid-operation: immediate return to IDLE, all strobes low, partial fill discarded with no block write.

Test Plan (N_WORDS_PER_BLOCK=4, BW_DATA=32):
- Fill, back-to-back: cmd addr=5, evict=0; rdata 0x11,0x22,0x33,0x44 on consecutive cycles -> one wren cycle with addr=5, mem_data_block_o=0x00000044_00000033_00000022_00000011; done 1 cycle later.
- Fill with gaps: rvalid gaps of 0-3 random cycles -> same block result; exactly 4 beats consumed; no early wren.
- Evict with backpressure: cache model returns 0xD_C_B_A block for addr=9; wready toggles -> words A,B,C,D in order; each held stable while stalled; wlast only on D; done after D.
- Reset mid-fill: assert reset_n_i low after 2 beats -> no wren ever; after release cmd_ready=1; a new fill to addr=2 completes correctly with counter starting at 0.
- Command gating: cmd_valid held high during a fill -> only one accept; next accept occurs the cycle after done.
- Stray inputs: rvalid pulses in IDLE/evict and wready in IDLE/fill -> no state change, counter unchanged.
